// File: rtl/top_k_tracker.sv
// Running top-K tracker: keeps the K best samples seen, sorted best-first, readable by rank.
// Optional duplicate suppression is compiled in with the TOPK_DEDUP_EN macro.
module top_k_tracker #(
   parameter int DATA_WIDTH = 32,
   parameter int K          = 4,
   parameter int MAX_MODE   = 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     clear,
   input  logic                     din_valid,
   input  logic [DATA_WIDTH-1:0]    din,
   input  logic [$clog2(K)-1:0]     rank,
   output logic [DATA_WIDTH-1:0]    dout,
   output logic                     dout_valid,
   output logic [$clog2(K+1)-1:0]   fill
);

   localparam int FILL_W = $clog2(K+1);
   localparam logic [FILL_W-1:0] FULL = FILL_W'(K);
   localparam logic [FILL_W-1:0] ONE  = FILL_W'(1);

   logic [DATA_WIDTH-1:0] e_q [K];
   logic [DATA_WIDTH-1:0] e_d [K];
   logic [FILL_W-1:0]     fill_q, fill_d;
   logic [FILL_W-1:0]     ins_pos;
   logic                  dup_hit;
   logic                  accept;

   // Entries are sorted, so counting the ones at least as good as din gives its slot
   // and keeps equal values in arrival order.
   always_comb begin
      ins_pos = '0;
      for (int i = 0; i < K; i++) begin
         if (i < int'(fill_q)) begin
            if (MAX_MODE != 0) begin
               if (e_q[i] >= din) ins_pos = ins_pos + ONE;
            end else begin
               if (e_q[i] <= din) ins_pos = ins_pos + ONE;
            end
         end
      end
   end

`ifdef TOPK_DEDUP_EN
   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < K; i++) begin
         if ((i < int'(fill_q)) && (e_q[i] == din)) dup_hit = 1'b1;
      end
   end
`else
   assign dup_hit = 1'b0;
`endif

   assign accept = din_valid && !clear && (ins_pos != FULL) && !dup_hit;

   always_comb begin
      e_d    = e_q;
      fill_d = fill_q;
      if (clear) begin
         for (int i = 0; i < K; i++) e_d[i] = '0;
         fill_d = '0;
      end else if (accept) begin
         if (ins_pos == '0) e_d[0] = din;
         for (int i = 1; i < K; i++) begin
            if (int'(ins_pos) == i) begin
               e_d[i] = din;
            end else if (int'(ins_pos) < i) begin
               e_d[i] = e_q[i-1];
            end
         end
         if (fill_q != FULL) fill_d = fill_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < K; i++) e_q[i] <= '0;
         fill_q <= '0;
      end else begin
         for (int i = 0; i < K; i++) e_q[i] <= e_d[i];
         fill_q <= fill_d;
      end
   end

   always_comb begin
      dout       = '0;
      dout_valid = 1'b0;
      if (int'(rank) < int'(fill_q)) begin
         dout       = e_q[rank];
         dout_valid = 1'b1;
      end
   end

   assign fill = fill_q;

endmodule

// File: tb/tb_top_k_tracker.sv
// Randomized self-checking bench for top_k_tracker: a K=4 max tracker and a K=2 min tracker
// share one stimulus stream and are compared against a sorted-list reference model.
module tb_top_k_tracker;

   logic        clk;
   logic        resetn;
   logic        clear;
   logic        din_valid;
   logic [31:0] din;
   logic [1:0]  rank_a;
   logic [0:0]  rank_b;
   logic [31:0] dout_a, dout_b;
   logic        dout_valid_a, dout_valid_b;
   logic [2:0]  fill_a;
   logic [1:0]  fill_b;

   int vectors;
   int miscompares;

   // Reference model: per tracker a best-first list, its size, capacity and ordering sense
   logic [31:0] mdl [2][16];
   int          mcnt [2];
   int          mk [2];
   bit          mmax [2];

   top_k_tracker #(.DATA_WIDTH(32), .K(4), .MAX_MODE(1)) dut_a (
      .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
      .rank(rank_a), .dout(dout_a), .dout_valid(dout_valid_a), .fill(fill_a)
   );

   top_k_tracker #(.DATA_WIDTH(32), .K(2), .MAX_MODE(0)) dut_b (
      .clk(clk), .resetn(resetn), .clear(clear), .din_valid(din_valid), .din(din),
      .rank(rank_b), .dout(dout_b), .dout_valid(dout_valid_b), .fill(fill_b)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      for (int m = 0; m < 2; m++) begin
         mcnt[m] = 0;
         for (int i = 0; i < 16; i++) mdl[m][i] = '0;
      end
   endtask

   // A new sample goes after every entry it does not strictly beat; the tail falls off.
   task automatic modelStep(input int m, input logic [31:0] d);
      int p;
      bit beats;
`ifdef TOPK_DEDUP_EN
      for (int i = 0; i < mcnt[m]; i++) if (mdl[m][i] == d) return;
`endif
      p = mcnt[m];
      for (int i = mcnt[m] - 1; i >= 0; i--) begin
         beats = mmax[m] ? (d > mdl[m][i]) : (d < mdl[m][i]);
         if (beats) p = i;
      end
      if (p >= mk[m]) return;
      for (int i = mk[m] - 1; i > p; i--) mdl[m][i] = mdl[m][i-1];
      mdl[m][p] = d;
      if (mcnt[m] < mk[m]) mcnt[m]++;
   endtask

   task automatic applyStimulus(input bit c, input bit v, input logic [31:0] d);
      clear     = c;
      din_valid = v;
      din       = d;
      @(posedge clk);
      if (c) modelReset();
      else if (v) begin
         modelStep(0, d);
         modelStep(1, d);
      end
      #1;
      clear     = 1'b0;
      din_valid = 1'b0;
      din       = $urandom;
   endtask

   task automatic checkAll();
      logic [31:0] exp_a, exp_b;
      checkOutput("fill_a", 32'(fill_a), 32'(mcnt[0]));
      checkOutput("fill_b", 32'(fill_b), 32'(mcnt[1]));
      for (int r = 0; r < 4; r++) begin
         rank_a = 2'(r);
         rank_b = 1'(r % 2);
         #1;
         exp_a = (r < mcnt[0]) ? mdl[0][r] : 32'd0;
         checkOutput($sformatf("dout_a[%0d]", r), dout_a, exp_a);
         checkOutput($sformatf("dvalid_a[%0d]", r), 32'(dout_valid_a), 32'(r < mcnt[0]));
         if (r < 2) begin
            exp_b = (r < mcnt[1]) ? mdl[1][r] : 32'd0;
            checkOutput($sformatf("dout_b[%0d]", r), dout_b, exp_b);
            checkOutput($sformatf("dvalid_b[%0d]", r), 32'(dout_valid_b), 32'(r < mcnt[1]));
         end
      end
   endtask

   task automatic checkRankA(input int r, input logic [31:0] exp);
      rank_a = 2'(r);
      #1;
      checkOutput($sformatf("directed_a[%0d]", r), dout_a, exp);
   endtask

   task automatic checkRankB(input int r, input logic [31:0] exp);
      rank_b = 1'(r);
      #1;
      checkOutput($sformatf("directed_b[%0d]", r), dout_b, exp);
   endtask

   // Reset pulsed between edges must empty both trackers without waiting for a clock
   task automatic pulseReset();
      #2;
      din_valid = 1'b1;
      din       = 32'd77;
      resetn    = 1'b0;
      #1;
      checkOutput("async_fill_a", 32'(fill_a), 32'd0);
      checkOutput("async_fill_b", 32'(fill_b), 32'd0);
      checkOutput("async_dvalid_a", 32'(dout_valid_a), 32'd0);
      checkOutput("async_dout_a", dout_a, 32'd0);
      #1;
      resetn    = 1'b1;
      din_valid = 1'b0;
      modelReset();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      mk[0] = 4; mmax[0] = 1'b1;
      mk[1] = 2; mmax[1] = 1'b0;
      modelReset();
      resetn = 1'b0; clear = 1'b0; din_valid = 1'b0; din = 32'd123;
      rank_a = '0; rank_b = '0;

      #15;
      checkAll();
      #4 resetn = 1'b1;

      // Four distinct samples on consecutive cycles
      applyStimulus(0, 1, 32'd5);
      applyStimulus(0, 1, 32'd9);
      applyStimulus(0, 1, 32'd3);
      applyStimulus(0, 1, 32'd7);
      checkOutput("directed_fill4", 32'(fill_a), 32'd4);
      checkRankA(0, 32'd9); checkRankA(1, 32'd7); checkRankA(2, 32'd5); checkRankA(3, 32'd3);
      checkAll();

      applyStimulus(0, 1, 32'd2);
      checkRankA(3, 32'd3);
      applyStimulus(0, 1, 32'd8);
      checkOutput("directed_fill_sat", 32'(fill_a), 32'd4);
      checkRankA(0, 32'd9); checkRankA(1, 32'd8); checkRankA(2, 32'd7); checkRankA(3, 32'd5);
      checkAll();

      // Ignored din when not valid, then duplicates
      applyStimulus(0, 0, 32'hFFFF_FFFF);
      checkAll();
      applyStimulus(1, 0, 32'd0);
      applyStimulus(0, 1, 32'd6);
      applyStimulus(0, 1, 32'd6);
`ifdef TOPK_DEDUP_EN
      checkOutput("dup_fill", 32'(fill_a), 32'd1);
      rank_a = 2'd1; #1;
      checkOutput("dup_rank1_valid", 32'(dout_valid_a), 32'd0);
`else
      checkOutput("dup_fill", 32'(fill_a), 32'd2);
      checkRankA(0, 32'd6); checkRankA(1, 32'd6);
`endif
      checkAll();

      // Clear wins over a same-cycle sample
      applyStimulus(1, 1, 32'd50);
      rank_a = 2'd0; #1;
      checkOutput("clear_fill", 32'(fill_a), 32'd0);
      checkOutput("clear_dout", dout_a, 32'd0);
      checkOutput("clear_dvalid", 32'(dout_valid_a), 32'd0);
      checkAll();

      // Min tracker with K=2
      applyStimulus(0, 1, 32'd4);
      applyStimulus(0, 1, 32'd1);
      applyStimulus(0, 1, 32'd9);
      applyStimulus(0, 1, 32'd0);
      checkRankB(0, 32'd0); checkRankB(1, 32'd1);
      checkAll();
      pulseReset();
      checkAll();

      for (int n = 0; n < 400; n++) begin
         logic [31:0] d;
         d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, d);
         checkAll();
         if (n == 200) begin
            pulseReset();
            checkAll();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
